// File: rtl/line_delay_sp_ctrl.sv
// Single-port SRAM line delay. Incoming pixels are packed four to a word and
// written per group; the previous line's word for the same group is read
// before it is overwritten. Each accepted pixel leaves the block exactly
// three cycles later, carrying the same-column pixel from the previous line.
module line_delay_sp_ctrl #(
  parameter int PIX_W = 10,
  parameter int ADDR  = 12,
  parameter int DEPTH = 2336
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [11:0]        line_groups,
  input  logic               bist_busy,
  input  logic               in_sof,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [PIX_W-1:0]   in_pix,
  output logic               out_vld,
  output logic [PIX_W-1:0]   out_pix,
  output logic               out_first,
  output logic               err_cfg,
  output logic               sram_CEN,
  output logic               sram_WEN,
  output logic [ADDR-1:0]    sram_A,
  output logic [4*PIX_W-1:0] sram_D,
  input  logic [4*PIX_W-1:0] sram_Q
);

  localparam int          WW      = 4 * PIX_W;
  localparam logic [11:0] DEPTH_L = 12'(DEPTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t            state_q, state_d;
  logic [11:0]       lg_q, lg_d;
  logic [1:0]        phase_q, phase_d;
  logic [ADDR-1:0]   group_q, group_d;
  logic [WW-1:0]     pack_q, pack_d;
  logic [WW-1:0]     old_word_q, old_word_d;
  logic              err_q, err_d;
  logic              cen_q, cen_d, wen_q, wen_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [WW-1:0]     wdata_q, wdata_d;
  logic              cap_q, cap_d;
  // two pipeline stages between acceptance and the output register
  logic [1:0]        vld_pipe_q, vld_pipe_d;
  logic [1:0]        first_pipe_q, first_pipe_d;
  logic [1:0][1:0]   ph_pipe_q, ph_pipe_d;
  logic              out_vld_q, out_vld_d, out_first_q, out_first_d;
  logic [PIX_W-1:0]  out_pix_q, out_pix_d;

  logic              acc, sof_acc, cfg_bad, grp_last;
  logic [ADDR-1:0]   last_grp;
  logic [WW-1:0]     word;

  assign in_rdy   = ~bist_busy;
  assign acc      = in_vld & ~bist_busy;
  assign sof_acc  = acc & in_sof;
  assign cfg_bad  = (line_groups < 12'd2) || (line_groups > DEPTH_L);
  assign last_grp = ADDR'(lg_q - 12'd1);
  assign grp_last = (group_q == last_grp);
  // a read issued last cycle returns its data now; bypass it straight to the output
  assign word     = cap_q ? sram_Q : old_word_q;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: bist wins, then frame start, then end of the first line
  always_comb begin
    state_d = state_q;
    if (bist_busy)
      state_d = IDLE;
    else if (sof_acc)
      state_d = cfg_bad ? IDLE : FILL;
    else if (acc && state_q == FILL && phase_q == 2'd3 && grp_last)
      state_d = RUN;
  end

  // FSM outputs: counters, packing, SRAM command and pipeline entry
  always_comb begin
    lg_d          = lg_q;
    phase_d       = phase_q;
    group_d       = group_q;
    pack_d        = pack_q;
    err_d         = err_q;
    cen_d         = 1'b1;
    wen_d         = 1'b1;
    addr_d        = '0;
    wdata_d       = wdata_q;
    vld_pipe_d    = {vld_pipe_q[0], 1'b0};
    first_pipe_d  = {first_pipe_q[0], (state_q == FILL)};
    ph_pipe_d     = {ph_pipe_q[0], phase_q};
    if (bist_busy) begin
      phase_d = '0;
      group_d = '0;
      pack_d  = '0;
    end else if (sof_acc) begin
      lg_d    = line_groups;
      phase_d = '0;
      group_d = '0;
      pack_d  = '0;
      if (cfg_bad) begin
        err_d = 1'b1;
      end else begin
        pack_d[PIX_W-1:0] = in_pix;
        phase_d           = 2'd1;
        vld_pipe_d[0]     = 1'b1;
        first_pipe_d[0]   = 1'b1;
        ph_pipe_d[0]      = 2'd0;
      end
    end else if (acc && state_q != IDLE) begin
      vld_pipe_d[0]                      = 1'b1;
      pack_d[int'(phase_q)*PIX_W +: PIX_W] = in_pix;
      phase_d                            = phase_q + 2'd1;
      if (phase_q == 2'd3) begin
        cen_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = group_q;
        wdata_d = {in_pix, pack_q[3*PIX_W-1:0]};
        group_d = grp_last ? '0 : group_q + ADDR'(1);
      end else if (phase_q == 2'd0 && state_q == RUN) begin
        cen_d  = 1'b0;
        addr_d = group_q;
      end
    end
  end

  // read-return capture and output stage
  always_comb begin
    cap_d       = ~cen_q & wen_q;
    old_word_d  = word;
    out_vld_d   = vld_pipe_q[1];
    out_first_d = vld_pipe_q[1] & first_pipe_q[1];
    out_pix_d   = '0;
    if (vld_pipe_q[1] && !first_pipe_q[1])
      out_pix_d = word[int'(ph_pipe_q[1])*PIX_W +: PIX_W];
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lg_q         <= '0;
      phase_q      <= '0;
      group_q      <= '0;
      pack_q       <= '0;
      old_word_q   <= '0;
      err_q        <= 1'b0;
      cen_q        <= 1'b1;
      wen_q        <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      cap_q        <= 1'b0;
      vld_pipe_q   <= '0;
      first_pipe_q <= '0;
      ph_pipe_q    <= '0;
      out_vld_q    <= 1'b0;
      out_first_q  <= 1'b0;
      out_pix_q    <= '0;
    end else begin
      lg_q         <= lg_d;
      phase_q      <= phase_d;
      group_q      <= group_d;
      pack_q       <= pack_d;
      old_word_q   <= old_word_d;
      err_q        <= err_d;
      cen_q        <= cen_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cap_q        <= cap_d;
      vld_pipe_q   <= vld_pipe_d;
      first_pipe_q <= first_pipe_d;
      ph_pipe_q    <= ph_pipe_d;
      out_vld_q    <= out_vld_d;
      out_first_q  <= out_first_d;
      out_pix_q    <= out_pix_d;
    end
  end

  assign out_vld   = out_vld_q;
  assign out_pix   = out_pix_q;
  assign out_first = out_first_q;
  assign err_cfg   = err_q;
  assign sram_CEN  = cen_q;
  assign sram_WEN  = wen_q;
  assign sram_A    = addr_q;
  assign sram_D    = wdata_q;

endmodule

// File: tb/tb_line_delay_sp_ctrl.sv
// Directed bench for line_delay_sp_ctrl with a behavioural single-port SRAM.
module tb_line_delay_sp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] line_groups;
  logic        bist_busy, in_sof, in_vld, in_rdy;
  logic [9:0]  in_pix, out_pix;
  logic        out_vld, out_first, err_cfg;
  logic        sram_CEN, sram_WEN;
  logic [11:0] sram_A;
  logic [39:0] sram_D, sram_Q;

  int n_asrt = 0;
  int n_fail = 0;

  logic [39:0] mem [0:4095];
  logic [39:0] q = '0;

  // expected output for pixels driven 0/1/2 ticks ago
  logic       ev [3];
  logic [9:0] ep [3];
  logic       ef [3];
  logic [52:0] acc_log [$];

  always #5 clk = ~clk;

  line_delay_sp_ctrl dut (
    .clk(clk), .rst_n(rst_n), .line_groups(line_groups), .bist_busy(bist_busy),
    .in_sof(in_sof), .in_vld(in_vld), .in_rdy(in_rdy), .in_pix(in_pix),
    .out_vld(out_vld), .out_pix(out_pix), .out_first(out_first), .err_cfg(err_cfg),
    .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A), .sram_D(sram_D),
    .sram_Q(sram_Q)
  );

  // single-port SRAM, read data valid the cycle after the read is sampled
  always @(posedge clk) begin
    if (!sram_CEN) begin
      if (sram_WEN) q <= mem[sram_A];
      else          mem[sram_A] <= sram_D;
    end
  end
  assign sram_Q = q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int b);
    logic [9:0] p0, p1, p2, p3;
    p0 = 10'(b); p1 = 10'(b + 1); p2 = 10'(b + 2); p3 = 10'(b + 3);
    return {p3, p2, p1, p0};
  endfunction

  // one clock: drive, clock, then sample the following cycle at the falling edge
  task automatic tick(input logic v, input logic s, input int p,
                      input logic e_v, input int e_p, input logic e_f);
    in_vld = v; in_sof = s; in_pix = 10'(p);
    ev[2] = ev[1]; ep[2] = ep[1]; ef[2] = ef[1];
    ev[1] = ev[0]; ep[1] = ep[0]; ef[1] = ef[0];
    ev[0] = e_v;   ep[0] = 10'(e_p); ef[0] = e_f;
    @(posedge clk);
    @(negedge clk);
    chk("out_vld", out_vld, ev[2]);
    if (ev[2]) begin
      chk("out_pix", out_pix, ep[2]);
      chk("out_first", out_first, ef[2]);
    end
    if (!sram_CEN) acc_log.push_back({sram_WEN, sram_A, sram_D});
    else begin
      chk("idle_WEN", sram_WEN, 1'b1);
      chk("idle_A", sram_A, 12'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  task automatic exp_wr(input int a, input logic [39:0] d);
    logic [52:0] e;
    if (acc_log.size() == 0) chk("wr_missing", 0, 1);
    else begin
      e = acc_log.pop_front();
      chk("wr_kind", e[52], 1'b0);
      chk("wr_addr", e[51:40], 12'(a));
      chk("wr_data", e[39:0], d);
    end
  endtask

  task automatic exp_rd(input int a);
    logic [52:0] e;
    if (acc_log.size() == 0) chk("rd_missing", 0, 1);
    else begin
      e = acc_log.pop_front();
      chk("rd_kind", e[52], 1'b1);
      chk("rd_addr", e[51:40], 12'(a));
    end
  endtask

  task automatic log_empty(input string tag);
    chk(tag, acc_log.size(), 0);
    acc_log.delete();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 3; i++) begin ev[i] = 0; ep[i] = 0; ef[i] = 0; end
    rst_n = 1'b0; line_groups = 12'd2; bist_busy = 1'b0;
    in_sof = 1'b0; in_vld = 1'b0; in_pix = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_out_pix", out_pix, 10'd0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_err", err_cfg, 1'b0);
    chk("rst_CEN", sram_CEN, 1'b1);
    chk("rst_WEN", sram_WEN, 1'b1);
    chk("rst_A", sram_A, 12'd0);
    chk("rst_D", sram_D, 40'd0);
    chk("rst_in_rdy", in_rdy, 1'b1);
    rst_n = 1'b1;

    // first line: pack and write, no reads, zeros flagged first
    for (int i = 0; i < 8; i++) tick(1'b1, i == 0, i, 1'b1, 0, 1'b1);
    idle(3);
    exp_wr(0, pk(0));
    exp_wr(1, pk(4));
    log_empty("fill_extra_acc");

    // second line: previous line comes out, read before write per group
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 100 + i, 1'b1, i, 1'b0);
    idle(3);
    exp_rd(0); exp_wr(0, pk(100));
    exp_rd(1); exp_wr(1, pk(104));
    log_empty("run_extra_acc");

    // third line with a bubble after every pixel
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b0, 200 + i, 1'b1, 100 + i, 1'b0);
      tick(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    end
    idle(3);
    exp_rd(0); exp_wr(0, pk(200));
    exp_rd(1); exp_wr(1, pk(204));
    log_empty("bubble_extra_acc");

    // in_sof at phase 2 of group 1: partial group dropped, restart in FILL
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 300 + i, 1'b1, 200 + i, 1'b0);
    tick(1'b1, 1'b1, 400, 1'b1, 0, 1'b1);
    for (int i = 1; i < 4; i++) tick(1'b1, 1'b0, 400 + i, 1'b1, 0, 1'b1);
    idle(3);
    exp_rd(0); exp_wr(0, pk(300));
    exp_rd(1); exp_wr(0, pk(400));
    log_empty("midsof_extra_acc");

    // bist takes the SRAM mid-line; in-flight pixels still emerge
    tick(1'b1, 1'b0, 500, 1'b1, 0, 1'b1);
    tick(1'b1, 1'b0, 501, 1'b1, 0, 1'b1);
    bist_busy = 1'b1;
    #1 chk("bist_in_rdy", in_rdy, 1'b0);
    tick(1'b1, 1'b0, 502, 1'b0, 0, 1'b0);
    chk("bist_CEN", sram_CEN, 1'b1);
    tick(1'b1, 1'b0, 503, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    bist_busy = 1'b0;
    #1 chk("bist_rel_in_rdy", in_rdy, 1'b1);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0, 600 + i, 1'b0, 0, 1'b0);
    idle(3);
    log_empty("bist_extra_acc");

    // largest legal line width
    line_groups = 12'd2336;
    tick(1'b1, 1'b1, 700, 1'b1, 0, 1'b1);
    for (int i = 1; i < 4; i++) tick(1'b1, 1'b0, 700 + i, 1'b1, 0, 1'b1);
    idle(3);
    exp_wr(0, pk(700));
    log_empty("max_extra_acc");
    chk("max_err", err_cfg, 1'b0);

    // one past the limit: error, idle, no access
    line_groups = 12'd2337;
    tick(1'b1, 1'b1, 800, 1'b0, 0, 1'b0);
    for (int i = 1; i < 8; i++) tick(1'b1, 1'b0, 800 + i, 1'b0, 0, 1'b0);
    idle(3);
    chk("bad_err", err_cfg, 1'b1);
    log_empty("bad_extra_acc");

    // error is sticky across a later legal frame
    line_groups = 12'd2;
    tick(1'b1, 1'b1, 900, 1'b1, 0, 1'b1);
    for (int i = 1; i < 4; i++) tick(1'b1, 1'b0, 900 + i, 1'b1, 0, 1'b1);
    idle(3);
    exp_wr(0, pk(900));
    log_empty("sticky_extra_acc");
    chk("sticky_err", err_cfg, 1'b1);

    // asynchronous reset clears the sticky error
    rst_n = 1'b0;
    #1;
    chk("rst2_err", err_cfg, 1'b0);
    chk("rst2_CEN", sram_CEN, 1'b1);
    chk("rst2_D", sram_D, 40'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
